// File: rtl/button_pkg.sv
// Shared definitions for the push-button gesture path: FSM state encoding and
// default timing derived from the board clock.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESSED     = 3'd1,
    HOLD        = 3'd2,
    WAIT_SECOND = 3'd3,
    SECOND_HELD = 3'd4,
    LOCKOUT     = 3'd5
  } state_t;

  localparam int unsigned CLK_HZ              = 24_000_000;
  // 500 ms hold, 125 ms double-press gap, 250 ms lockout
  localparam int unsigned DEF_LONG_CYCLES     = CLK_HZ / 2;
  localparam int unsigned DEF_GAP_CYCLES      = CLK_HZ / 8;
  localparam int unsigned DEF_LOCKOUT_CYCLES  = CLK_HZ / 4;

endpackage

// File: rtl/button_gesture_decoder.sv
// Classifies debounced press/release pulses into short, long and double press
// events, then holds off further input for a lockout window.
module button_gesture_decoder
  import button_pkg::*;
#(
  parameter int          CNT_W          = 24,
  parameter int unsigned LONG_CYCLES    = DEF_LONG_CYCLES,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic press_in,
  input  logic release_in,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             short_nx, long_nx, double_nx;
  logic             timed;

  assign timed = (state == PRESSED) || (state == WAIT_SECOND) || (state == LOCKOUT);

  // Release is checked before the threshold/press so ties resolve as specified.
  always_comb begin
    state_nx  = state;
    short_nx  = 1'b0;
    long_nx   = 1'b0;
    double_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_in) state_nx = PRESSED;
      end
      PRESSED: begin
        if (release_in) begin
          state_nx = WAIT_SECOND;
        end else if (cnt == LONG_LAST) begin
          state_nx = HOLD;
          long_nx  = 1'b1;
        end
      end
      HOLD: begin
        if (release_in) state_nx = LOCKOUT;
      end
      WAIT_SECOND: begin
        if (press_in) begin
          state_nx  = SECOND_HELD;
          double_nx = 1'b1;
        end else if (cnt == GAP_LAST) begin
          state_nx = LOCKOUT;
          short_nx = 1'b1;
        end
      end
      SECOND_HELD: begin
        if (release_in) state_nx = LOCKOUT;
      end
      LOCKOUT: begin
        if (cnt == LOCK_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      short_press  <= short_nx;
      long_press   <= long_nx;
      double_press <= double_nx;
      busy         <= (state_nx != IDLE);
      // Counter restarts on every state entry and saturates rather than wrapping.
      if (state_nx != state) begin
        cnt <= '0;
      end else if (timed && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Scenario bench for button_gesture_decoder with small timing parameters.
module tb_button_gesture_decoder;

  typedef struct {
    int         cyc;
    logic [2:0] code;   // {short, long, double}
  } ev_t;

  localparam logic [2:0] EV_SHORT  = 3'b100;
  localparam logic [2:0] EV_LONG   = 3'b010;
  localparam logic [2:0] EV_DOUBLE = 3'b001;
  localparam int         MAXC      = 64;

  logic clk = 1'b0;
  logic reset, press_in, release_in;
  logic short_press, long_press, double_press, busy;

  int n_tests = 0;
  int n_fail  = 0;

  ev_t sb[$];
  bit  pr[MAXC];
  bit  rl[MAXC];
  bit  rs[MAXC];
  bit  bz[MAXC];

  button_gesture_decoder #(
    .CNT_W         (8),
    .LONG_CYCLES   (8),
    .GAP_CYCLES    (4),
    .LOCKOUT_CYCLES(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .press_in    (press_in),
    .release_in  (release_in),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_scn();
    for (int i = 0; i < MAXC; i++) begin
      pr[i] = 1'b0;
      rl[i] = 1'b0;
      rs[i] = 1'b0;
      bz[i] = 1'b0;
    end
    sb.delete();
  endtask

  task automatic set_busy(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) bz[i] = 1'b1;
  endtask

  task automatic push_ev(input int c, input logic [2:0] code);
    ev_t e;
    e.cyc  = c;
    e.code = code;
    sb.push_back(e);
  endtask

  // Caller is just after a rising edge; cycle i spans edge i .. edge i+1.
  task automatic run_scn(input string name, input int len);
    logic [2:0] exp_code;
    for (int i = 0; i < len; i++) begin
      press_in   = pr[i];
      release_in = rl[i];
      reset      = rs[i];
      @(negedge clk);
      exp_code = 3'b000;
      while (sb.size() > 0 && sb[0].cyc < i) begin
        check_val($sformatf("%s_stale_c%0d", name, sb[0].cyc), 32'd1, 32'd0);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == i) begin
        exp_code = sb[0].code;
        void'(sb.pop_front());
      end
      check_val($sformatf("%s_evt_c%0d", name, i),
                {29'd0, short_press, long_press, double_press}, {29'd0, exp_code});
      check_val($sformatf("%s_busy_c%0d", name, i), {31'd0, busy}, {31'd0, bz[i]});
      @(posedge clk);
      #1;
    end
    press_in   = 1'b0;
    release_in = 1'b0;
    reset      = 1'b0;
    check_val($sformatf("%s_sb_left", name), sb.size(), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    press_in   = 1'b0;
    release_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_short",  {31'd0, short_press},  32'd0);
    check_val("rst_long",   {31'd0, long_press},   32'd0);
    check_val("rst_double", {31'd0, double_press}, 32'd0);
    check_val("rst_busy",   {31'd0, busy},         32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Short press: release at 3, gap expires at 7, lockout 8..10.
    clr_scn();
    pr[0] = 1; rl[3] = 1;
    push_ev(8, EV_SHORT);
    set_busy(1, 10);
    run_scn("short", 14);

    // Long press: threshold at 8, release at 20, lockout 21..23.
    clr_scn();
    pr[0] = 1; rl[20] = 1;
    push_ev(9, EV_LONG);
    set_busy(1, 23);
    run_scn("long", 27);

    // Double press: second press at 4, release at 15, lockout 16..18.
    clr_scn();
    pr[0] = 1; rl[2] = 1; pr[4] = 1; rl[15] = 1;
    push_ev(5, EV_DOUBLE);
    set_busy(1, 18);
    run_scn("double", 22);

    // Release on the long threshold cycle wins: short press instead.
    clr_scn();
    pr[0] = 1; rl[8] = 1;
    push_ev(13, EV_SHORT);
    set_busy(1, 15);
    run_scn("tie_long", 19);

    // Second press on the gap timeout cycle wins: double press.
    clr_scn();
    pr[0] = 1; rl[3] = 1; pr[7] = 1; rl[10] = 1;
    push_ev(8, EV_DOUBLE);
    set_busy(1, 13);
    run_scn("tie_gap", 17);

    // Pulses inside lockout ignored; press on first IDLE cycle (11) accepted.
    clr_scn();
    pr[0] = 1; rl[3] = 1; pr[9] = 1; rl[10] = 1; pr[11] = 1; rl[13] = 1;
    push_ev(8, EV_SHORT);
    push_ev(18, EV_SHORT);
    set_busy(1, 10);
    set_busy(12, 20);
    run_scn("lockout", 25);

    // Reset in cycle 2 of PRESSED abandons the gesture with no event.
    clr_scn();
    pr[0] = 1; rs[2] = 1;
    set_busy(1, 2);
    run_scn("reset_mid", 14);

    clr_scn();
    pr[0] = 1; rl[3] = 1;
    push_ev(8, EV_SHORT);
    set_busy(1, 10);
    run_scn("short_after_rst", 14);

    // Simultaneous pulses in PRESSED: release is taken.
    clr_scn();
    pr[0] = 1; pr[2] = 1; rl[2] = 1;
    push_ev(7, EV_SHORT);
    set_busy(1, 9);
    run_scn("both_pressed", 13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
